// File: rtl/ps2_pkg.sv
// PS/2 host-to-device transmitter: shared state enum and frame constants.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    DATA,
    ACK,
    WAIT_IDLE
  } state_t;

  // Falling-edge numbers within a host-to-device frame.
  localparam int         DATA_BITS   = 8;
  localparam logic [3:0] EDGE_PARITY = 4'd9;
  localparam logic [3:0] EDGE_STOP   = 4'd10;
  localparam logic [3:0] EDGE_ACK    = 4'd11;

  // Odd parity: the returned bit makes data plus parity hold an odd count of ones.
  function automatic logic odd_parity(input logic [DATA_BITS-1:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_sync_filter.sv
// Two-flop synchronizer for a raw PS/2 line, optionally followed by a
// stability filter that only passes a new level after FILTER_LEN cycles.
// Everything presets to line-high (idle bus) while reset is asserted.
module ps2_sync_filter #(
  parameter int FILTER_LEN = 8,
  parameter bit FILTER_EN  = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  logic [1:0] sync;

  // Metastability guard; idle PS/2 lines are high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync <= 2'b11;
    else        sync <= {sync[0], din};
  end

  generate
    if (FILTER_EN) begin : g_filt
      localparam int CW = $clog2(FILTER_LEN + 1);
      logic [CW-1:0] cnt;
      logic          level;

      // A differing level must persist FILTER_LEN cycles in a row to be taken.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt   <= '0;
          level <= 1'b1;
        end else if (sync[1] == level) begin
          cnt <= '0;
        end else if (cnt == CW'(FILTER_LEN - 1)) begin
          level <= sync[1];
          cnt   <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end

      assign dout = level;
    end else begin : g_raw
      assign dout = sync[1];
    end
  endgenerate

endmodule

// File: rtl/ps2_tx.sv
// PS/2 host command transmitter (open-drain clock/data enables).
// Optional feature: define PS2_TX_ACK_CHECK_EN to report a device nack on
// err_nack; without it the ack bit is clocked but ignored.
module ps2_tx
  import ps2_pkg::*;
#(
  parameter int CLK_HZ      = 50000000,
  parameter int INHIBIT_CYC = 5000,
  parameter int TIMEOUT_CYC = 750000,
  parameter int FILTER_LEN  = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2c_in,
  input  logic       ps2d_in,
  output logic       ps2c_oe,
  output logic       ps2d_oe,
  output logic       busy,
  output logic       tx_done,
  output logic       err_timeout,
  output logic       err_nack
);

  // One counter serves the inhibit timer and then the watchdog.
  localparam int MAXC = (TIMEOUT_CYC > INHIBIT_CYC) ? TIMEOUT_CYC : INHIBIT_CYC;
  localparam int CW   = $clog2(MAXC + 1);

  generate
    if (INHIBIT_CYC < 2 || TIMEOUT_CYC < 2 || FILTER_LEN < 1 || CLK_HZ < 1) begin : g_bad_cfg
      $error("ps2_tx: invalid parameter set");
    end
  endgenerate

  state_t        state;
  logic [CW-1:0] cnt;
  logic [3:0]    bitcnt;
  logic [3:0]    bit_nx;
  logic [7:0]    data_q;
  logic          par_q;
  logic          c_f;
  logic          c_prev;
  logic          d_s;
  logic          fall;
`ifdef PS2_TX_ACK_CHECK_EN
  logic          nack_q;
`else
  assign err_nack = 1'b0;
`endif

  ps2_sync_filter #(.FILTER_LEN(FILTER_LEN), .FILTER_EN(1'b1)) u_clk_filt (
    .clk(clk), .rst_n(rst_n), .din(ps2c_in), .dout(c_f)
  );

  ps2_sync_filter #(.FILTER_LEN(FILTER_LEN), .FILTER_EN(1'b0)) u_dat_sync (
    .clk(clk), .rst_n(rst_n), .din(ps2d_in), .dout(d_s)
  );

  // Previous filtered clock level for falling-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) c_prev <= 1'b1;
    else        c_prev <= c_f;
  end

  assign fall   = c_prev & ~c_f;
  assign bit_nx = (bitcnt == EDGE_ACK) ? bitcnt : bitcnt + 4'd1;

  // Frame sequencer with registered line enables and status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      bitcnt      <= '0;
      data_q      <= '0;
      par_q       <= 1'b0;
      ps2c_oe     <= 1'b0;
      ps2d_oe     <= 1'b0;
      tx_ready    <= 1'b0;
      busy        <= 1'b0;
      tx_done     <= 1'b0;
      err_timeout <= 1'b0;
`ifdef PS2_TX_ACK_CHECK_EN
      nack_q      <= 1'b0;
      err_nack    <= 1'b0;
`endif
    end else begin
      tx_done     <= 1'b0;
      err_timeout <= 1'b0;
`ifdef PS2_TX_ACK_CHECK_EN
      err_nack    <= 1'b0;
`endif
      case (state)
        IDLE: begin
          tx_ready <= 1'b1;
          busy     <= 1'b0;
          if (tx_valid && tx_ready) begin
            data_q   <= tx_data;
            par_q    <= odd_parity(tx_data);
            bitcnt   <= '0;
            cnt      <= '0;
            ps2c_oe  <= 1'b1;
            tx_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= INHIBIT;
          end
        end
        INHIBIT: begin
          cnt <= cnt + CW'(1);
          // Start bit goes onto data during the last inhibit cycle.
          if (cnt == CW'(INHIBIT_CYC - 2)) ps2d_oe <= 1'b1;
          if (cnt == CW'(INHIBIT_CYC - 1)) begin
            ps2c_oe <= 1'b0;
            ps2d_oe <= 1'b1;
            cnt     <= '0;
            state   <= REQ;
          end
        end
        default: begin
          // Watchdog covers everything after the inhibit phase.
          if (cnt == CW'(TIMEOUT_CYC - 1)) begin
            ps2c_oe     <= 1'b0;
            ps2d_oe     <= 1'b0;
            err_timeout <= 1'b1;
            tx_ready    <= 1'b1;
            busy        <= 1'b0;
            state       <= IDLE;
          end else begin
            cnt <= cnt + CW'(1);
            case (state)
              REQ: if (c_f) state <= DATA;
              DATA: if (fall) begin
                bitcnt <= bit_nx;
                if (bit_nx <= 4'(DATA_BITS))   ps2d_oe <= ~data_q[bitcnt[2:0]];
                else if (bit_nx == EDGE_PARITY) ps2d_oe <= ~par_q;
                else if (bit_nx == EDGE_STOP) begin
                  ps2d_oe <= 1'b0;
                  state   <= ACK;
                end
              end
              ACK: if (fall) begin
                bitcnt <= bit_nx;
`ifdef PS2_TX_ACK_CHECK_EN
                nack_q <= d_s;
`endif
                state  <= WAIT_IDLE;
              end
              WAIT_IDLE: if (c_f && d_s) begin
`ifdef PS2_TX_ACK_CHECK_EN
                tx_done  <= ~nack_q;
                err_nack <= nack_q;
`else
                tx_done  <= 1'b1;
`endif
                tx_ready <= 1'b1;
                busy     <= 1'b0;
                state    <= IDLE;
              end
              default: state <= IDLE;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_tx.sv
// Bench for ps2_tx: a PS/2 device model clocks frames out of the DUT and the
// received bits and outcome pulses are compared against a byte-level model.
module tb_ps2_tx;

  localparam int INH = 50;
  localparam int TMO = 2000;
  localparam int FL  = 8;
  localparam int H   = 30;   // device clock half-period in system cycles

  localparam int R_DONE = 0;
  localparam int R_NACK = 1;
`ifdef PS2_TX_ACK_CHECK_EN
  localparam int R_NACKED = R_NACK;
`else
  localparam int R_NACKED = R_DONE;
`endif

  typedef struct {
    logic [7:0] data;
    bit         ack;
    bit         glitch;
    bit         exp_par;
    int         exp_res;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, ps2c_oe, ps2d_oe, busy, tx_done, err_timeout, err_nack;
  logic       dev_c = 1'b1;
  logic       dev_d = 1'b1;
  logic       ps2c_in, ps2d_in;

  // Open-drain bus: either side can pull a line low.
  assign ps2c_in = ~ps2c_oe & dev_c;
  assign ps2d_in = ~ps2d_oe & dev_d;

  int vectors = 0;
  int miscompares = 0;
  int n_done = 0, n_nack = 0, n_to = 0, n_multi = 0;

  ps2_tx #(.CLK_HZ(50000000), .INHIBIT_CYC(INH), .TIMEOUT_CYC(TMO), .FILTER_LEN(FL)) dut (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .ps2c_in(ps2c_in), .ps2d_in(ps2d_in), .ps2c_oe(ps2c_oe), .ps2d_oe(ps2d_oe), .busy(busy),
    .tx_done(tx_done), .err_timeout(err_timeout), .err_nack(err_nack)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (tx_done) n_done++;
    if (err_nack) n_nack++;
    if (err_timeout) n_to++;
    if (int'(tx_done) + int'(err_nack) + int'(err_timeout) > 1) n_multi++;
  end

  initial begin
    #1000000;
    $display("FAIL global_time_limit: actual expired, required finish");
    $fatal(1, "time limit");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: actual %0d, required %0d", nm, act, exp);
    end
  endtask

  function automatic bit model_parity(input logic [7:0] b);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    return (ones % 2 == 0);
  endfunction

  task automatic send(input logic [7:0] b, input bit poke);
    int w = 0;
    while (!tx_ready && w < 5000) begin tick(1); w++; end
    check("ready_before_send", int'(tx_ready), 1);
    tx_data  = b;
    tx_valid = 1'b1;
    tick(1);
    tx_valid = 1'b0;
    tx_data  = ~b;
    check("busy_after_accept", int'(busy), 1);
    if (poke) begin
      tx_valid = 1'b1;   // must be ignored while busy
      tick(4);
      tx_valid = 1'b0;
    end
  endtask

  task automatic wait_req();
    int w = 0;
    while (!(ps2c_oe == 1'b0 && ps2d_oe == 1'b1) && w < 500) begin tick(1); w++; end
    check("req_phase_seen", int'(w < 500), 1);
  endtask

  task automatic dev_frame(input bit ack, input bit glitch, output logic [10:0] got);
    got = '1;
    wait_req();
    tick(20);
    got[0] = ps2d_in;
    for (int k = 1; k <= 11; k++) begin
      dev_c = 1'b0;
      tick(H);
      dev_c = 1'b1;
      if (k == 11) begin
        tick(5);
        dev_d = 1'b1;
      end else begin
        if (glitch && k == 3) begin
          tick(8); dev_c = 1'b0; tick(3); dev_c = 1'b1; tick(H - 13);
        end else begin
          tick(H - 2);
        end
        got[k] = ps2d_in;
        if (k == 10 && ack) dev_d = 1'b0;
        tick(2);
      end
    end
  endtask

  task automatic run_frame(input string nm, input logic [7:0] b, input bit ack,
                           input bit glitch, input bit exp_par, input int exp_res);
    logic [10:0] got;
    int d0, k0, t0, w;
    d0 = n_done; k0 = n_nack; t0 = n_to;
    send(b, 1'b1);
    dev_frame(ack, glitch, got);
    check({nm, "_start"}, int'(got[0]), 0);
    for (int i = 0; i < 8; i++) check($sformatf("%s_d%0d", nm, i), int'(got[i+1]), int'(b[i]));
    check({nm, "_parity"}, int'(got[9]), int'(exp_par));
    check({nm, "_stop"}, int'(got[10]), 1);
    w = 0;
    while ((n_done + n_nack + n_to) == (d0 + k0 + t0) && w < 300) begin tick(1); w++; end
    tick(20);
    check({nm, "_done_cnt"}, n_done - d0, int'(exp_res == R_DONE));
    check({nm, "_nack_cnt"}, n_nack - k0, int'(exp_res == R_NACK));
    check({nm, "_tmo_cnt"}, n_to - t0, 0);
    check({nm, "_ready"}, int'(tx_ready), 1);
    check({nm, "_lines_released"}, int'(ps2c_oe | ps2d_oe), 0);
  endtask

  initial begin
    vec_t tbl[5];
    int d0, k0, t0, n, fd, m;
    logic [7:0] rb;
    bit ra, rg;

    tbl[0] = '{8'hED, 1'b1, 1'b0, 1'b1, R_DONE};
    tbl[1] = '{8'h07, 1'b1, 1'b0, 1'b0, R_DONE};
    tbl[2] = '{8'h00, 1'b1, 1'b0, 1'b1, R_DONE};
    tbl[3] = '{8'hAA, 1'b0, 1'b1, 1'b1, R_NACKED};
    tbl[4] = '{8'h3C, 1'b1, 1'b1, 1'b1, R_DONE};

    // Reset state
    tick(3);
    check("rst_ps2c_oe", int'(ps2c_oe), 0);
    check("rst_ps2d_oe", int'(ps2d_oe), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_tx_ready", int'(tx_ready), 0);
    check("rst_pulses", int'(tx_done | err_timeout | err_nack), 0);
    rst_n = 1'b1;
    tick(1);
    check("ready_first_edge", int'(tx_ready), 1);

    for (int i = 0; i < 5; i++)
      run_frame($sformatf("tbl%0d", i), tbl[i].data, tbl[i].ack, tbl[i].glitch,
                tbl[i].exp_par, tbl[i].exp_res);

    for (int i = 0; i < 6; i++) begin
      rb = 8'($urandom_range(0, 255));
      ra = 1'($urandom_range(0, 1));
      rg = 1'($urandom_range(0, 1));
      run_frame($sformatf("rnd%0d", i), rb, ra, rg, model_parity(rb), ra ? R_DONE : R_NACKED);
    end

    // Inhibit width, then a silent device runs into the watchdog
    d0 = n_done; k0 = n_nack; t0 = n_to;
    send(8'h5A, 1'b0);
    n = 0; fd = 0;
    while (ps2c_oe && n < 200) begin
      n++;
      if (ps2d_oe && fd == 0) fd = n;
      tick(1);
    end
    check("inhibit_len", n, INH);
    check("start_bit_cycle", fd, INH);
    m = 0;
    while (!err_timeout && m < 3000) begin tick(1); m++; end
    check("timeout_cycles", m, TMO);
    check("timeout_ps2c_oe", int'(ps2c_oe), 0);
    check("timeout_ps2d_oe", int'(ps2d_oe), 0);
    check("timeout_ready", int'(tx_ready), 1);
    tick(1);
    check("timeout_single_pulse", int'(err_timeout), 0);
    tick(10);
    check("timeout_tmo_cnt", n_to - t0, 1);
    check("timeout_other_cnt", (n_done - d0) + (n_nack - k0), 0);

    // Reset in the middle of a frame
    d0 = n_done; k0 = n_nack; t0 = n_to;
    send(8'h01, 1'b1);
    wait_req();
    tick(20);
    for (int k = 1; k <= 5; k++) begin
      dev_c = 1'b0; tick(H); dev_c = 1'b1; tick(H);
    end
    check("abort_pre_ps2d_oe", int'(ps2d_oe), 1);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_ps2c_oe", int'(ps2c_oe), 0);
    check("abort_ps2d_oe", int'(ps2d_oe), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_ready", int'(tx_ready), 0);
    tick(3);
    rst_n = 1'b1;
    tick(3);
    check("abort_no_pulse", (n_done - d0) + (n_nack - k0) + (n_to - t0), 0);
    run_frame("after_abort", 8'hF4, 1'b1, 1'b0, 1'b0, R_DONE);

    check("pulses_exclusive", n_multi, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
